pcm_i2s_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 28 ++
 rtl/pcm_i2s_tx_if.sv | 22 ++
 rtl/i2s_bclk_gen.sv | 34 +++
 rtl/pcm_i2s_tx.sv | 126 ++++++++++++
 tb/tb_pcm_i2s_tx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants, sample type and I2S slot classification helper.
package audio_pkg;

    localparam int PCM_W                = 16;
    localparam int I2S_SLOT_BITS        = 32;
    localparam int I2S_FRAME_BITS       = 64;
    localparam int I2S_BCLK_DIV_DEFAULT = 20;

    typedef logic signed [PCM_W-1:0] pcm_sample_t;

    typedef enum logic [1:0] {
        SLOT_PAD   = 2'd0,
        SLOT_LEFT  = 2'd1,
        SLOT_RIGHT = 2'd2
    } slot_kind_t;

    // Position b within a 64-bit frame carries a sample bit when its slot
    // offset (b mod 32) lies in 1..w; the upper half of the frame is right.
    function automatic slot_kind_t slot_kind(input logic [5:0] b, input int unsigned w);
        logic [4:0] pos;
        pos = b[4:0];
        if ((pos != 5'd0) && (32'(pos) <= w)) begin
            return b[5] ? SLOT_RIGHT : SLOT_LEFT;
        end
        return SLOT_PAD;
    endfunction

endpackage

// File: rtl/pcm_i2s_tx_if.sv
// PCM sample bus from the decimators into the I2S transmitter.
interface pcm_i2s_tx_if
    import audio_pkg::*;
#(
    parameter int W = PCM_W
);
    logic                pcm_valid;
    logic signed [W-1:0] pcm_left;
    logic signed [W-1:0] pcm_right;

    modport master (
        output pcm_valid,
        output pcm_left,
        output pcm_right
    );

    modport slave (
        input pcm_valid,
        input pcm_left,
        input pcm_right
    );
endinterface

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: bclk register plus one-cycle rise/fall strobes that
// coincide with the clk edge on which bclk toggles.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] TC = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tc;

    assign tc        = (div_cnt == TC);
    assign bclk_rise = tc & ~bclk;
    assign bclk_fall = tc & bclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/pcm_i2s_tx.sv
// Stereo Philips-I2S transmitter with one-sample double buffering.
// Define I2S_TX_STATUS_EN to implement the sticky underrun/overrun flags.
module pcm_i2s_tx
    import audio_pkg::*;
#(
    parameter int W        = PCM_W,
    parameter int BCLK_DIV = I2S_BCLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    pcm_i2s_tx_if.slave pcm,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun,
    output logic        overrun
);
    localparam int CW = $clog2(I2S_FRAME_BITS);

    logic                bclk_rise;
    logic                bclk_fall;
    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       b_next;
    logic                load;
    logic                next_bit;
    logic                next_bit_d;
    logic signed [W-1:0] stage_l;
    logic signed [W-1:0] stage_r;
    logic signed [W-1:0] shift_l;
    logic signed [W-1:0] shift_r;
    logic [W-1:0]        sel_l;
    logic [W-1:0]        sel_r;
    logic [4:0]          bit_idx;
    slot_kind_t          kind;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    // The bit for the next slot is picked on the preceding rise and only
    // registered onto sdata at the fall; the shifter never changes in between
    // except at a load, whose slot is always padding.
    always_comb begin
        b_next     = bit_cnt + CW'(1);
        load       = bclk_fall && (b_next == '0);
        kind       = slot_kind(b_next, W);
        bit_idx    = 5'(W) - b_next[4:0];
        sel_l      = shift_l >> bit_idx;
        sel_r      = shift_r >> bit_idx;
        next_bit_d = 1'b0;
        case (kind)
            SLOT_LEFT:  next_bit_d = sel_l[0];
            SLOT_RIGHT: next_bit_d = sel_r[0];
            default:    next_bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '1;
            lrclk       <= 1'b1;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            next_bit    <= 1'b0;
            stage_l     <= '0;
            stage_r     <= '0;
            shift_l     <= '0;
            shift_r     <= '0;
        end else begin
            frame_start <= load;
            if (bclk_rise) begin
                next_bit <= next_bit_d;
            end
            if (bclk_fall) begin
                bit_cnt <= b_next;
                lrclk   <= (int'(b_next) >= I2S_SLOT_BITS);
                sdata   <= next_bit;
            end
            // Without a fresh sample the staging registers still hold the last
            // loaded pair, so an unconditional load resends the previous frame.
            if (load) begin
                shift_l <= stage_l;
                shift_r <= stage_r;
            end
            if (pcm.pcm_valid) begin
                stage_l <= pcm.pcm_left;
                stage_r <= pcm.pcm_right;
            end
        end
    end

`ifdef I2S_TX_STATUS_EN
    logic staged;

    always_ff @(posedge clk) begin
        if (rst) begin
            staged   <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (pcm.pcm_valid) begin
                staged <= 1'b1;
            end else if (load) begin
                staged <= 1'b0;
            end
            if (load && !staged) begin
                underrun <= 1'b1;
            end
            if (pcm.pcm_valid && staged && !load) begin
                overrun <= 1'b1;
            end
        end
    end
`else
    assign underrun = 1'b0;
    assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Self-checking bench for pcm_i2s_tx: frame-level reference model plus
// directed scenarios with literal expectations (flags depend on I2S_TX_STATUS_EN).
module tb_pcm_i2s_tx;
    import audio_pkg::*;

    localparam int W = PCM_W;
    localparam int D = I2S_BCLK_DIV_DEFAULT;
    localparam int P = 2 * D;
`ifdef I2S_TX_STATUS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic bclk, lrclk, sdata, frame_start, underrun, overrun;

    pcm_i2s_tx_if #(.W(W)) pcm_bus ();

    pcm_i2s_tx #(
        .W        (W),
        .BCLK_DIV (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pcm         (pcm_bus),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state: n counts clk edges since reset release.
    int          n = 0;
    bit          started = 1'b0;
    logic [W-1:0] st_l, st_r, cur_l, cur_r;
    bit          staged_m, und_m, ovr_m;

    function automatic bit is_load(input int nn);
        return (nn > 0) && (nn % P == 0) && (((nn / P) - 1) % 64 == 0);
    endfunction

    function automatic logic exp_lrclk(input int nn);
        int k;
        k = nn / P;
        if (k == 0) return 1'b1;
        return ((k - 1) % 64) >= 32;
    endfunction

    function automatic logic exp_sdata(input int nn, input logic [W-1:0] l, input logic [W-1:0] r);
        int k;
        int b;
        k = nn / P;
        if (k == 0) return 1'b0;
        b = (k - 1) % 64;
        if (b >= 1 && b <= W) return l[W - b];
        if (b >= 33 && b <= 32 + W) return r[W - b + 32];
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h (n=%0d)", name, act, exp, n);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started  <= 1'b1;
            n        <= 0;
            st_l     <= '0;
            st_r     <= '0;
            cur_l    <= '0;
            cur_r    <= '0;
            staged_m <= 1'b0;
            und_m    <= 1'b0;
            ovr_m    <= 1'b0;
        end else begin
            n <= n + 1;
            if (is_load(n + 1)) begin
                cur_l <= st_l;
                cur_r <= st_r;
                if (!staged_m) und_m <= 1'b1;
            end
            if (pcm_bus.pcm_valid) begin
                st_l     <= pcm_bus.pcm_left;
                st_r     <= pcm_bus.pcm_right;
                staged_m <= 1'b1;
                if (staged_m && !is_load(n + 1)) ovr_m <= 1'b1;
            end else if (is_load(n + 1)) begin
                staged_m <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cycle", {bclk, lrclk, sdata, frame_start, underrun, overrun},
                  {((n / D) % 2) == 1, exp_lrclk(n), exp_sdata(n, cur_l, cur_r),
                   is_load(n), FLAGS_ON & und_m, FLAGS_ON & ovr_m});
        end
    end

    task automatic wait_n(input int target);
        for (int i = 0; i < 40000 && n != target; i++) @(negedge clk);
        if (n != target) begin
            total++;
            $display("FAIL wait_n: reached n=%0d, required n=%0d", n, target);
            $display("%0d/%0d checks passed", passed, total);
            $fatal(1, "timeout");
        end
    endtask

    task automatic drive_at(input int target, input logic [W-1:0] l, input logic [W-1:0] r);
        wait_n(target - 1);
        pcm_bus.pcm_left  = l;
        pcm_bus.pcm_right = r;
        pcm_bus.pcm_valid = 1'b1;
        @(negedge clk);
        pcm_bus.pcm_valid = 1'b0;
    endtask

    // Samples sdata/lrclk at the middle of every slot (bclk high) of frame f.
    task automatic check_frame(input int f, input logic [W-1:0] el, input logic [W-1:0] er,
                               input string tag);
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [63:0]  lr;
        logic         other;
        l = '0; r = '0; lr = '0; other = 1'b0;
        for (int b = 0; b < 64; b++) begin
            wait_n(P * (64 * f + 1 + b) + D);
            lr[b] = lrclk;
            if (b >= 1 && b <= W) l[W - b] = sdata;
            else if (b >= 33 && b <= 32 + W) r[W - b + 32] = sdata;
            else other = other | sdata;
        end
        check({tag, "_left"}, l, el);
        check({tag, "_right"}, r, er);
        check({tag, "_pad"}, other, 1'b0);
        check({tag, "_lrclk"}, lr, 64'hFFFF_FFFF_0000_0000);
    endtask

    initial begin
        rst = 1'b1;
        pcm_bus.pcm_valid = 1'b0;
        pcm_bus.pcm_left  = '0;
        pcm_bus.pcm_right = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_n(D - 1);  check("bclk_pre_rise", bclk, 1'b0);
        wait_n(D);      check("bclk_first_rise", bclk, 1'b1);
        wait_n(P - 1);  check("lrclk_pre_fall", {bclk, lrclk, sdata}, 3'b110);
        wait_n(P);      check("first_fall", {bclk, lrclk, frame_start}, 3'b001);
        wait_n(P + 1);  check("underrun_idle", underrun, FLAGS_ON);

        drive_at(100, 16'h8001, 16'h7FFE);
        fork
            check_frame(1, 16'h8001, 16'h7FFE, "f1");
            begin
                drive_at(3000, 16'hAAAA, 16'hBBBB);
                drive_at(P * (64 * 2 + 1), 16'h5555, 16'h6666);
            end
        join
        wait_n(P * (64 * 2 + 1) + 10);
        check("no_overrun_on_load", overrun, 1'b0);
        check_frame(2, 16'hAAAA, 16'hBBBB, "f2");

        fork
            check_frame(3, 16'h5555, 16'h6666, "f3");
            begin
                drive_at(P * (64 * 3 + 1) + 80, 16'h1111, 16'h2222);
                drive_at(P * (64 * 3 + 1) + 180, 16'h3333, 16'h4444);
                wait_n(P * (64 * 3 + 1) + 190);
                check("overrun", overrun, FLAGS_ON);
            end
        join
        check_frame(4, 16'h3333, 16'h4444, "f4");

        // Reset mid slot 20 of frame 5.
        wait_n(P * (64 * 5 + 1 + 20) + D - 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_frame", {bclk, lrclk, sdata, frame_start, underrun, overrun}, 6'b010000);
        @(negedge clk);
        rst = 1'b0;
        check_frame(0, 16'h0000, 16'h0000, "post_rst");
        check("underrun_post_rst", {underrun, overrun}, {FLAGS_ON, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
